// File: rtl/speech_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : speech_capture_if
//  Description : Control, sample-input and speech-RAM-write signal bundle
//                for speech_capture. The slave modport is the capture block;
//                the master modport is the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface speech_capture_if #(
  parameter int ADDR_W = 20
);
  // System -> capture block
  logic              arm;
  logic [15:0]       sample_in;
  logic              sample_valid;
  logic              result_ack;
  // Capture block -> speech RAM / recognizer
  logic [ADDR_W-1:0] speech_addr;
  logic [15:0]       speech_data;
  logic              speech_wren;
  logic              start;
  logic [ADDR_W:0]   sample_count;
  logic              full;
  logic              busy;

  modport master (
    output arm, sample_in, sample_valid, result_ack,
    input  speech_addr, speech_data, speech_wren, start, sample_count, full, busy
  );

  modport slave (
    input  arm, sample_in, sample_valid, result_ack,
    output speech_addr, speech_data, speech_wren, start, sample_count, full, busy
  );
endinterface : speech_capture_if
`default_nettype wire

// File: rtl/speech_capture.sv
`default_nettype none
// ============================================================================
//  Module      : speech_capture
//  Description : Energy-gated speech capture. Listens to a PCM stream, stores
//                samples into speech RAM, detects an utterance from per-frame
//                energy with hangover, then launches the recognizer and waits
//                for its acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module speech_capture #(
  parameter int          FRAME_LEN   = 256,
  parameter int          ADDR_W      = 20,
  parameter int          MAX_SAMPLES = 2**ADDR_W,
  parameter logic [23:0] ENERGY_TH   = 24'd200000,
  parameter int          HANG_FRAMES = 8,
  parameter int          MIN_FRAMES  = 4
) (
  input logic             clk,
  input logic             reset,   // asynchronous, active-low
  speech_capture_if.slave bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_FBITS = $clog2(FRAME_LEN);
  localparam int c_ACC_W = 16 + c_FBITS;
  localparam int c_SIL_W = $clog2(HANG_FRAMES + 1);

  localparam logic [ADDR_W:0]      c_MAX       = (ADDR_W+1)'(MAX_SAMPLES);
  localparam logic [c_SIL_W-1:0]   c_HANG_LAST = c_SIL_W'(HANG_FRAMES - 1);
  localparam logic [7:0]           c_MIN       = 8'(MIN_FRAMES);
  localparam logic [31:0]          c_TH        = {8'd0, ENERGY_TH};

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LISTEN   = 3'd1;
  localparam logic [2:0] c_ST_SPEECH   = 3'd2;
  localparam logic [2:0] c_ST_DONE     = 3'd3;
  localparam logic [2:0] c_ST_WAIT_ACK = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]          state_q,        state_d;
  logic [ADDR_W:0]     ptr_q,          ptr_d;
  logic [c_FBITS-1:0]  fcnt_q,         fcnt_d;
  logic [c_ACC_W-1:0]  acc_q,          acc_d;
  logic [c_ACC_W-1:0]  energy_q,       energy_d;
  logic                frame_end_q,    frame_end_d;
  logic [7:0]          voiced_q,       voiced_d;
  logic [c_SIL_W-1:0]  silent_q,       silent_d;
  logic [ADDR_W-1:0]   speech_addr_q,  speech_addr_d;
  logic [15:0]         speech_data_q,  speech_data_d;
  logic                speech_wren_q,  speech_wren_d;
  logic                start_q,        start_d;
  logic [ADDR_W:0]     sample_count_q, sample_count_d;
  logic                full_q,         full_d;
  logic                busy_q,         busy_d;

  // Control strobes from the state machine to the datapath
  logic                ptr_rst;    // discard stored frames, restart at address 0
  logic                clear_all;  // fresh capture session (arm edge either way)
  logic                set_full;   // capture stopped by the capacity limit

  logic                w_cap_q;    // currently capturing
  logic                w_cap_d;    // still capturing after this cycle
  logic                w_accept;   // this cycle's sample is stored
  logic                w_at_max;   // pointer has hit capacity
  logic                w_voiced;   // last completed frame exceeds threshold
  logic [14:0]         w_neg;
  logic [14:0]         w_abs;
  logic [c_ACC_W-1:0]  w_acc_sum;
  logic [ADDR_W:0]     w_ptr_base;

  assign w_cap_q  = (state_q == c_ST_LISTEN) || (state_q == c_ST_SPEECH);
  assign w_cap_d  = (state_d == c_ST_LISTEN) || (state_d == c_ST_SPEECH);
  assign w_at_max = (ptr_q == c_MAX);
  assign w_voiced = ({{(32-c_ACC_W){1'b0}}, energy_q} > c_TH);

  // A sample is stored only when capture continues through this cycle, so a
  // sample that coincides with leaving LISTEN/SPEECH is dropped.
  assign w_accept = bus.sample_valid && w_cap_q && w_cap_d;

  // Magnitude of the incoming sample; -32768 clamps to 32767 so the frame
  // sum of FRAME_LEN magnitudes always fits 16+log2(FRAME_LEN) bits.
  always_comb begin
    w_neg = 15'd0 - bus.sample_in[14:0];
    if (!bus.sample_in[15]) begin
      w_abs = bus.sample_in[14:0];
    end else if (bus.sample_in == 16'h8000) begin
      w_abs = 15'h7FFF;
    end else begin
      w_abs = w_neg;
    end
  end

  assign w_acc_sum = acc_q + {{(c_ACC_W-15){1'b0}}, w_abs};

  // Utterance state machine: arm gating, frame decisions, capacity stop, handshake.
  always_comb begin
    state_d   = state_q;
    voiced_d  = voiced_q;
    silent_d  = silent_q;
    ptr_rst   = 1'b0;
    clear_all = 1'b0;
    set_full  = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.arm) begin
          state_d   = c_ST_LISTEN;
          clear_all = 1'b1;
        end
      end
      c_ST_LISTEN, c_ST_SPEECH: begin
        if (!bus.arm) begin
          state_d   = c_ST_IDLE;
          clear_all = 1'b1;
        end else if (w_at_max) begin
          // Capacity stop outranks any frame decision pending this cycle.
          state_d  = c_ST_DONE;
          set_full = 1'b1;
        end else if (frame_end_q) begin
          if (state_q == c_ST_LISTEN) begin
            if (w_voiced) begin
              state_d  = c_ST_SPEECH;
              voiced_d = 8'd1;
              silent_d = '0;
            end else begin
              ptr_rst = 1'b1;
            end
          end else if (w_voiced) begin
            if (voiced_q != 8'hFF) begin
              voiced_d = voiced_q + 8'd1;
            end
            silent_d = '0;
          end else if (silent_q == c_HANG_LAST) begin
            silent_d = '0;
            if (voiced_q >= c_MIN) begin
              state_d = c_ST_DONE;
            end else begin
              // Too short to be an utterance: throw it away and keep listening.
              state_d  = c_ST_LISTEN;
              voiced_d = '0;
              ptr_rst  = 1'b1;
            end
          end else begin
            silent_d = silent_q + c_SIL_W'(1);
          end
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_WAIT_ACK;
      end
      c_ST_WAIT_ACK: begin
        if (bus.result_ack) begin
          state_d = c_ST_IDLE;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
    if (clear_all) begin
      voiced_d = '0;
      silent_d = '0;
    end
  end

  // Sample datapath: write port, pointer, frame counter and energy accumulator.
  always_comb begin
    w_ptr_base    = ptr_rst ? '0 : ptr_q;
    ptr_d         = w_ptr_base;
    fcnt_d        = fcnt_q;
    acc_d         = acc_q;
    energy_d      = energy_q;
    frame_end_d   = 1'b0;
    speech_wren_d = 1'b0;
    speech_addr_d = speech_addr_q;
    speech_data_d = speech_data_q;
    if (clear_all) begin
      ptr_d  = '0;
      fcnt_d = '0;
      acc_d  = '0;
    end else if (w_accept) begin
      speech_wren_d = 1'b1;
      speech_addr_d = w_ptr_base[ADDR_W-1:0];
      speech_data_d = bus.sample_in;
      ptr_d         = w_ptr_base + (ADDR_W+1)'(1);
      fcnt_d        = fcnt_q + c_FBITS'(1);
      if (&fcnt_q) begin
        // Last sample of the frame: publish the total and restart the sum
        // so the next frame accumulates from zero.
        frame_end_d = 1'b1;
        energy_d    = w_acc_sum;
        acc_d       = '0;
      end else begin
        acc_d = w_acc_sum;
      end
    end
  end

  // Registered status outputs, aligned with the state they describe.
  always_comb begin
    start_d        = (state_d == c_ST_DONE);
    busy_d         = (state_d == c_ST_DONE) || (state_d == c_ST_WAIT_ACK);
    sample_count_d = (state_d == c_ST_DONE) ? ptr_q : sample_count_q;
    full_d         = full_q;
    if (set_full) begin
      full_d = 1'b1;
    end else if (clear_all && (state_d == c_ST_LISTEN)) begin
      full_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= c_ST_IDLE;
      ptr_q          <= '0;
      fcnt_q         <= '0;
      acc_q          <= '0;
      energy_q       <= '0;
      frame_end_q    <= 1'b0;
      voiced_q       <= '0;
      silent_q       <= '0;
      speech_addr_q  <= '0;
      speech_data_q  <= '0;
      speech_wren_q  <= 1'b0;
      start_q        <= 1'b0;
      sample_count_q <= '0;
      full_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      fcnt_q         <= fcnt_d;
      acc_q          <= acc_d;
      energy_q       <= energy_d;
      frame_end_q    <= frame_end_d;
      voiced_q       <= voiced_d;
      silent_q       <= silent_d;
      speech_addr_q  <= speech_addr_d;
      speech_data_q  <= speech_data_d;
      speech_wren_q  <= speech_wren_d;
      start_q        <= start_d;
      sample_count_q <= sample_count_d;
      full_q         <= full_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.speech_addr  = speech_addr_q;
  assign bus.speech_data  = speech_data_q;
  assign bus.speech_wren  = speech_wren_q;
  assign bus.start        = start_q;
  assign bus.sample_count = sample_count_q;
  assign bus.full         = full_q;
  assign bus.busy         = busy_q;

endmodule : speech_capture
`default_nettype wire

// File: tb/tb_speech_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speech_capture
//  Description : Scoreboard bench for speech_capture. Stimulus queues the
//                expected RAM writes and start events; monitors compare them
//                against what the two DUT instances present.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_speech_capture;

  localparam int AW = 20;
  localparam int FL = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  speech_capture_if #(.ADDR_W(AW)) bus1 ();
  speech_capture_if #(.ADDR_W(AW)) bus2 ();

  speech_capture #(.ADDR_W(AW)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  speech_capture #(.ADDR_W(AW), .MAX_SAMPLES(1024)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct packed {
    logic [AW:0] cnt;
    logic        full;
  } st_t;

  wr_t wq1[$];
  wr_t wq2[$];
  st_t sq1[$];
  st_t sq2[$];

  int errors  = 0;
  int checks  = 0;
  int starts1 = 0;
  int starts2 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor for dut1: every write and every start is matched against the queues.
  always @(negedge clk) begin : mon1
    wr_t w;
    st_t s;
    if (reset) begin
      if (bus1.speech_wren) begin
        if (wq1.size() == 0) begin
          check("dut1_unexpected_write", 1, 0);
        end else begin
          w = wq1.pop_front();
          check("dut1_wr_addr", 64'(bus1.speech_addr), 64'(w.addr));
          check("dut1_wr_data", 64'(bus1.speech_data), 64'(w.data));
        end
      end
      if (bus1.start) begin
        starts1++;
        if (sq1.size() == 0) begin
          check("dut1_unexpected_start", 1, 0);
        end else begin
          s = sq1.pop_front();
          check("dut1_sample_count", 64'(bus1.sample_count), 64'(s.cnt));
          check("dut1_full", 64'(bus1.full), 64'(s.full));
        end
      end
    end
  end

  // Monitor for dut2 (small-capacity instance).
  always @(negedge clk) begin : mon2
    wr_t w;
    st_t s;
    if (reset) begin
      if (bus2.speech_wren) begin
        if (wq2.size() == 0) begin
          check("dut2_unexpected_write", 1, 0);
        end else begin
          w = wq2.pop_front();
          check("dut2_wr_addr", 64'(bus2.speech_addr), 64'(w.addr));
          check("dut2_wr_data", 64'(bus2.speech_data), 64'(w.data));
        end
      end
      if (bus2.start) begin
        starts2++;
        if (sq2.size() == 0) begin
          check("dut2_unexpected_start", 1, 0);
        end else begin
          s = sq2.pop_front();
          check("dut2_sample_count", 64'(bus2.sample_count), 64'(s.cnt));
          check("dut2_full", 64'(bus2.full), 64'(s.full));
        end
      end
    end
  end

  // One sample strobe every other cycle; called at a falling edge.
  task automatic send(input int which, input logic [15:0] x, input bit expw, input int addr);
    wr_t w;
    w.addr = AW'(addr);
    w.data = x;
    if (which == 1) begin
      if (expw) wq1.push_back(w);
      bus1.sample_in    = x;
      bus1.sample_valid = 1'b1;
    end else begin
      if (expw) wq2.push_back(w);
      bus2.sample_in    = x;
      bus2.sample_valid = 1'b1;
    end
    @(negedge clk);
    bus1.sample_valid = 1'b0;
    bus2.sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // A full frame of constant magnitude, optionally alternating sign.
  task automatic frame(input int which, input logic [15:0] v, input bit alt,
                       input bit expw, input int base);
    logic [15:0] x;
    for (int i = 0; i < FL; i++) begin
      x = (alt && (i % 2 == 1)) ? (16'd0 - v) : v;
      send(which, x, expw, base + i);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    st_t s;
    bus1.arm = 1'b0; bus1.sample_in = '0; bus1.sample_valid = 1'b0; bus1.result_ack = 1'b0;
    bus2.arm = 1'b0; bus2.sample_in = '0; bus2.sample_valid = 1'b0; bus2.result_ack = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wren",  64'(bus1.speech_wren),  0);
    check("rst_addr",  64'(bus1.speech_addr),  0);
    check("rst_start", 64'(bus1.start),        0);
    check("rst_busy",  64'(bus1.busy),         0);
    check("rst_full",  64'(bus1.full),         0);
    check("rst_count", 64'(bus1.sample_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // Silence: every frame discarded, address wraps to 0 each frame, no start
    bus1.arm = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 16; f++) frame(1, 16'd10, 1'b0, 1'b1, 0);
    settle();
    check("silence_no_start", 64'(starts1), 0);
    check("silence_writes_drained", 64'(wq1.size()), 0);
    bus1.arm = 1'b0;
    settle();

    // Utterance: 2 silent, 10 voiced, 8 silent frames; frames 3..20 are stored
    s.cnt = (AW+1)'(18 * FL);
    s.full = 1'b0;
    sq1.push_back(s);
    bus1.arm = 1'b1;
    @(negedge clk);
    frame(1, 16'd10, 1'b0, 1'b1, 0);
    frame(1, 16'd10, 1'b0, 1'b1, 0);
    for (int k = 0; k < 10; k++) frame(1, 16'd2000, 1'b1, 1'b1, k * FL);
    for (int k = 10; k < 18; k++) frame(1, 16'd10, 1'b0, 1'b1, k * FL);
    settle();
    check("utt_start_once", 64'(starts1), 1);
    check("utt_busy", 64'(bus1.busy), 1);

    // Acknowledge withheld: busy stays high, samples and arm toggles ignored
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus1.arm = (i % 2 == 0) ? 1'b0 : 1'b1;
      send(1, 16'd5000, 1'b0, 0);
      if (!bus1.busy) bad++;
    end
    check("wait_ack_busy_cycles_low", 64'(bad), 0);
    check("wait_ack_no_new_start", 64'(starts1), 1);
    bus1.arm = 1'b0;
    bus1.result_ack = 1'b1;
    @(negedge clk);
    bus1.result_ack = 1'b0;
    @(negedge clk);
    check("ack_busy_released", 64'(bus1.busy), 0);
    check("ack_count_held", 64'(bus1.sample_count), 64'(18 * FL));

    // Short burst: 2 voiced then 8 silent, back to LISTEN at address 0
    bus1.arm = 1'b1;
    @(negedge clk);
    frame(1, 16'd2000, 1'b1, 1'b1, 0);
    frame(1, 16'd2000, 1'b1, 1'b1, FL);
    for (int k = 2; k < 10; k++) frame(1, 16'd10, 1'b0, 1'b1, k * FL);
    send(1, 16'd77, 1'b1, 0);
    settle();
    check("burst_no_start", 64'(starts1), 1);
    check("burst_busy", 64'(bus1.busy), 0);
    bus1.arm = 1'b0;
    settle();

    // Saturation: a frame of -32768 sums to 256*32767 and is voiced
    bus1.arm = 1'b1;
    @(negedge clk);
    frame(1, 16'h8000, 1'b0, 1'b1, 0);
    check("sat_energy", 64'(dut1.energy_q), 64'd8388352);
    send(1, 16'd7, 1'b1, FL);   // voiced: pointer keeps counting

    // Asynchronous reset mid-SPEECH clears outputs without a clock edge
    bus1.sample_in = 16'd8;
    bus1.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.sample_valid = 1'b0;
    check("pre_reset_wren", 64'(bus1.speech_wren), 1);
    check("pre_reset_addr", 64'(bus1.speech_addr), 64'(FL + 1));
    #1 reset = 1'b0;
    #1;
    check("areset_wren",  64'(bus1.speech_wren),  0);
    check("areset_addr",  64'(bus1.speech_addr),  0);
    check("areset_data",  64'(bus1.speech_data),  0);
    check("areset_start", 64'(bus1.start),        0);
    check("areset_busy",  64'(bus1.busy),         0);
    check("areset_full",  64'(bus1.full),         0);
    check("areset_count", 64'(bus1.sample_count), 0);
    bus1.arm = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus1.arm = 1'b1;
    @(negedge clk);
    send(1, 16'd3, 1'b1, 0);
    settle();
    bus1.arm = 1'b0;

    // Overflow on the 1024-sample instance: stops at capacity, rest dropped
    s.cnt = (AW+1)'(1024);
    s.full = 1'b1;
    sq2.push_back(s);
    bus2.arm = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) frame(2, 16'd2000, 1'b1, 1'b1, k * FL);
    for (int i = 0; i < 4; i++) send(2, 16'd2000, 1'b0, 0);
    settle();
    check("ovf_start_once", 64'(starts2), 1);
    check("ovf_full_held", 64'(bus2.full), 1);
    check("ovf_busy", 64'(bus2.busy), 1);
    bus2.arm = 1'b0;
    bus2.result_ack = 1'b1;
    @(negedge clk);
    bus2.result_ack = 1'b0;
    @(negedge clk);
    check("ovf_ack_idle", 64'(bus2.busy), 0);
    check("ovf_full_until_listen", 64'(bus2.full), 1);
    bus2.arm = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_full_cleared_on_listen", 64'(bus2.full), 0);
    bus2.arm = 1'b0;
    settle();

    // Everything queued must have been observed
    check("dut1_writes_left", 64'(wq1.size()), 0);
    check("dut2_writes_left", 64'(wq2.size()), 0);
    check("dut1_starts_left", 64'(sq1.size()), 0);
    check("dut2_starts_left", 64'(sq2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_speech_capture
`default_nettype wire
